// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic                iss_ready_o,
  input  logic                wb_valid_i,
  input  logic [AW-1:0]       wb_rd_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                flush_i,
  output logic [AW:0]         busy_cnt_o
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;

  logic wb_we;
  logic iss_set;
  logic cnt_inc;
  logic cnt_dec;

  assign wb_we = wb_valid_i && (wb_rd_i != '0);

  // A writeback to the requested destination frees it in time for the new reservation.
  assign iss_ready_o = !busy_q[iss_rd_i] || (wb_valid_i && (wb_rd_i == iss_rd_i)) ||
                       (iss_rd_i == '0);
  assign iss_set     = iss_valid_i && iss_ready_o && !flush_i && (iss_rd_i != '0);

  assign cnt_inc = iss_set && !busy_q[iss_rd_i];
  assign cnt_dec = wb_we && busy_q[wb_rd_i] && !(iss_set && (iss_rd_i == wb_rd_i));

  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (flush_i) begin
      busy_d     = '0;
      busy_cnt_d = '0;
    end else begin
      if (wb_we) begin
        busy_d[wb_rd_i] = 1'b0;
      end
      // Issue is applied last so it wins over a same-register release.
      if (iss_set) begin
        busy_d[iss_rd_i] = 1'b1;
      end
      busy_cnt_d = busy_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_we) begin
      mem_q[wb_rd_i] <= wb_data_i;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign hit  = wb_valid_i && (wb_rd_i == addr) && (addr != '0);
`else
    assign hit  = 1'b0;
`endif
    assign rd_data_o[k*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? wb_data_i : mem_q[addr]);
    assign rd_busy_o[k]              = busy_q[addr] && !hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against a register/scoreboard array model.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic                clk, rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid, iss_ready, wb_valid, flush;
  logic [AW-1:0]       iss_rd, wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic [AW:0]         busy_cnt;

  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy [NREG];

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .iss_valid_i(iss_valid),
    .iss_rd_i   (iss_rd),
    .iss_ready_o(iss_ready),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
    .flush_i    (flush),
    .busy_cnt_o (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = '0;
    wb_valid  = 1'b0; wb_rd  = '0; wb_data = '0;
    flush     = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // Compare combinational outputs against the model, then advance the model one clock.
  task automatic step();
    logic [AW-1:0] a;
    bit            hit, exp_rdy, acc;
    int            cnt;
    #1;
    for (int k = 0; k < NRD; k++) begin
      a   = rd_addr[k*AW +: AW];
      hit = Byp && wb_valid && (wb_rd == a) && (a != 0);
      check_eq($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN],
               (a == 0) ? 64'd0 : (hit ? 64'(wb_data) : 64'(m_reg[a])));
      check_eq($sformatf("rd_busy%0d", k), 64'(rd_busy[k]),
               (a == 0 || hit) ? 64'd0 : 64'(m_busy[a]));
    end
    exp_rdy = !m_busy[iss_rd] || (wb_valid && wb_rd == iss_rd) || iss_rd == 0;
    check_eq("iss_ready", 64'(iss_ready), 64'(exp_rdy));
    cnt = 0;
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    check_eq("busy_cnt", 64'(busy_cnt), 64'(cnt));
    acc = iss_valid && exp_rdy && !flush;
    if (wb_valid && wb_rd != 0) m_reg[wb_rd] = wb_data;
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 1'b0;
      if (acc && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int r);
    idle(); iss_valid = 1'b1; iss_rd = AW'(r);
    step();
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < NRD; k++) begin
      check_eq({tag, "_data"}, rd_data[k*XLEN +: XLEN], 64'd0);
      check_eq({tag, "_busy"}, 64'(rd_busy[k]), 64'd0);
    end
    check_eq({tag, "_cnt"}, 64'(busy_cnt), 64'd0);
    check_eq({tag, "_ready"}, 64'(iss_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    set_rd(0, 0, 0);
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Issue x5, write it back two cycles later.
    set_rd(5, 0, 0);
    issue(5);
    #1;
    check_eq("x5_busy", 64'(rd_busy[0]), 64'd1);
    check_eq("x5_cnt1", 64'(busy_cnt), 64'd1);
    step();
    wb_valid = 1'b1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    step();
    idle();
    #1;
    check_eq("x5_data", rd_data[31:0], 64'hDEADBEEF);
    check_eq("x5_free", 64'(rd_busy[0]), 64'd0);
    check_eq("x5_cnt0", 64'(busy_cnt), 64'd0);

    // WAW stall on x7, then same-cycle writeback lets the issue through.
    set_rd(7, 0, 0);
    issue(7);
    iss_valid = 1'b1; iss_rd = 7;
    #1 check_eq("waw_stall", 64'(iss_ready), 64'd0);
    step();
    check_eq("waw_cnt", 64'(busy_cnt), 64'd1);
    iss_valid = 1'b1; iss_rd = 7;
    wb_valid = 1'b1; wb_rd = 7; wb_data = 32'h77;
    #1 check_eq("waw_ready", 64'(iss_ready), 64'd1);
    step();
    idle();
    #1;
    check_eq("waw_busy", 64'(rd_busy[0]), 64'd1);
    check_eq("waw_cnt2", 64'(busy_cnt), 64'd1);
    check_eq("waw_data", rd_data[31:0], 64'h77);
    wb_valid = 1'b1; wb_rd = 7; wb_data = 32'h78;
    step();
    idle();

    // x0 is hardwired.
    set_rd(0, 0, 0);
    wb_valid = 1'b1; wb_rd = 0; wb_data = 32'h1234;
    iss_valid = 1'b1; iss_rd = 0;
    step();
    idle();
    #1;
    check_eq("x0_data", rd_data[31:0], 64'd0);
    check_eq("x0_busy", 64'(rd_busy[0]), 64'd0);
    check_eq("x0_cnt", 64'(busy_cnt), 64'd0);

    // Flush with concurrent writeback and issue.
    issue(3); issue(4); issue(9);
    #1 check_eq("fl_cnt3", 64'(busy_cnt), 64'd3);
    flush = 1'b1;
    wb_valid = 1'b1; wb_rd = 4; wb_data = 32'h55;
    iss_valid = 1'b1; iss_rd = 10;
    set_rd(3, 4, 10);
    step();
    idle();
    #1;
    check_eq("fl_b3", 64'(rd_busy[0]), 64'd0);
    check_eq("fl_b4", 64'(rd_busy[1]), 64'd0);
    check_eq("fl_b10", 64'(rd_busy[2]), 64'd0);
    check_eq("fl_cnt", 64'(busy_cnt), 64'd0);
    check_eq("fl_x4", rd_data[63:32], 64'h55);

    // Same-cycle writeback to x12 seen on all three ports.
    set_rd(12, 12, 12);
    issue(12);
    wb_valid = 1'b1; wb_rd = 12; wb_data = 32'hA5A5A5A5;
    #1;
    for (int k = 0; k < NRD; k++) begin
      check_eq("byp_data", rd_data[k*XLEN +: XLEN], Byp ? 64'hA5A5A5A5 : 64'd0);
      check_eq("byp_busy", 64'(rd_busy[k]), Byp ? 64'd0 : 64'd1);
    end
    step();
    idle();
    #1;
    for (int k = 0; k < NRD; k++) begin
      check_eq("byp_next", rd_data[k*XLEN +: XLEN], 64'hA5A5A5A5);
    end

    // Randomized traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      iss_valid = ($urandom_range(0, 9) < 6);
      iss_rd    = AW'($urandom_range(0, 7));
      wb_valid  = ($urandom_range(0, 1) == 1);
      wb_rd     = AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 39) == 0);
      set_rd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
      step();
    end

    // Asynchronous reset mid-run with three registers busy.
    idle();
    flush = 1'b1;
    step();
    issue(2); issue(6); issue(8);
    set_rd(2, 6, 8);
    iss_rd = 2;
    #1 check_eq("pre_rst_cnt", 64'(busy_cnt), 64'd3);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = AW'($urandom_range(0, 7));
      wb_valid  = ($urandom_range(0, 1) == 1);
      wb_rd     = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = 1'b0;
      set_rd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a built-in busy scoreboard for the pipelined RISC-V core. It sits between decode/issue, which reads operands and reserves destinations, and writeback, which commits results and releases reservations. It generalises the single-cycle two-read register file in width, depth and read-port count. It adds per-register pending tracking, issue back-pressure on WAW, a pending counter and a flush.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, register count; power of two, ≥ 2
- NRD, 2, number of read ports, ≥ 1
- AW, $clog2(NREG), address width; derived, do not override

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]; combinational
- rd_busy  out  NRD  port k's register has a pending writer; combinational
- iss_valid  in  1  issue request reserving iss_rd
- iss_rd  in  AW  destination to reserve
- iss_ready  out  1  issue may be accepted this cycle; combinational
- wb_valid  in  1  writeback strobe
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  synchronous clear of all reservations
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Storage: NREG × XLEN array plus NREG busy bits. Register 0 is hardwired: it always reads 0 and is never busy. Writes and issues to register 0 are accepted and have no effect.
- Read: rd_data[k] = reg[rd_addr[k]] and rd_busy[k] = busy[rd_addr[k]], both purely combinational.
- Issue:
  - iss_ready = !busy[iss_rd] || (wb_valid && wb_rd == iss_rd) || iss_rd == 0.
  - Accept = iss_valid && iss_ready && !flush. On accept with iss_rd ≠ 0, busy[iss_rd] ← 1.
- Writeback: when wb_valid and wb_rd ≠ 0:
  - reg[wb_rd] ← wb_data, whether or not the register is busy.
  - busy[wb_rd] ← 0, unless an issue to the same register is accepted in the same cycle; issue wins and busy stays 1.
- Flush: all busy bits ← 0 and busy_cnt ← 0. A concurrent writeback still writes its data. A concurrent issue is dropped.
- busy_cnt:
  - +1 when an accepted issue sets a bit that was 0.
  - −1 when a writeback clears a bit that was 1.
  - Both events on the same register cancel to 0 net.
  - Writeback to a non-busy register leaves the count unchanged.
  - Maximum value is NREG−1; the counter never wraps.
- Reset (rst_n low, asynchronous): all registers = 0, all busy = 0, busy_cnt = 0.
  - Outputs then read 0: rd_data = 0, rd_busy = 0, iss_ready = 1.
  - Reset mid-operation discards all pending reservations.

## Timing
- Read latency 0 cycles, combinational from rd_addr.
- A write lands at the posedge where wb_valid is high. It is visible on rd_data from the next cycle, or in the same cycle under REGFILE_BYPASS_EN.
- Issue reservation is visible on rd_busy and iss_ready the cycle after accept.
- Writeback release is visible the cycle after the strobe, or in the same cycle under REGFILE_BYPASS_EN.
- busy_cnt is registered and updates one cycle after the causing event.

## Configuration
- REGFILE_BYPASS_EN defined:
  - For each read port with wb_valid && wb_rd == rd_addr[k] && rd_addr[k] ≠ 0, rd_data[k] = wb_data and rd_busy[k] = 0 in the same cycle.
  - iss_ready behaviour is unchanged.
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored array and busy bits only.
  - A same-cycle writeback is seen one cycle later.

## Test plan
- Reset then read: assert rst_n=0 mid-run with 3 registers busy -> immediately rd_data all 0, rd_busy all 0, busy_cnt=0, iss_ready=1.
- Issue x5, wb x5=0xDEADBEEF two cycles later:
  - Cycle after issue: rd_busy=1 on port reading x5, busy_cnt=1.
  - Cycle after wb: rd_data=0xDEADBEEF, rd_busy=0, busy_cnt=0.
- WAW stall: x7 busy, iss_valid with iss_rd=7 and no wb -> iss_ready=0, busy_cnt stays 1.
  - Same cycle with wb_rd=7 -> iss_ready=1, x7 written, busy stays 1, busy_cnt stays 1.
- x0 rules: wb_rd=0 with data 0x1234 and issue iss_rd=0 -> read x0 returns 0, rd_busy=0, busy_cnt unchanged.
- Flush: x3, x4, x9 busy; flush=1 with wb x4=0x55 and iss_rd=10 in the same cycle:
  - Next cycle: all busy=0, busy_cnt=0, x4 reads 0x55, x10 not busy.
- Bypass: with REGFILE_BYPASS_EN, wb x12=0xA5A5A5A5 while NRD=3 ports all read x12 -> all three return 0xA5A5A5A5 with rd_busy=0 that cycle.
  - Without the macro, the old value is returned that cycle and the new value the next.
